// File: rtl/fmesh_presel_ctrl_if.sv
// Handshake/bus bundle between the pre-selection controller and its neighbours.
//   enable        : controller active
//   credit_avb    : free credits per direction, slice d (0=E,1=N,2=W,3=S)
//   port_pre_sel  : per-quadrant X(0)/Y(1) port pre-selection
//   presel_update : one-cycle pulse when port_pre_sel is reloaded from a window
interface fmesh_presel_ctrl_if #(
  parameter int unsigned CRDw = 4
);
  logic                  enable;
  logic [4*CRDw-1:0]     credit_avb;
  logic [3:0]            port_pre_sel;
  logic                  presel_update;

  modport master (
    output enable,
    output credit_avb,
    input  port_pre_sel,
    input  presel_update
  );

  modport slave (
    input  enable,
    input  credit_avb,
    output port_pre_sel,
    output presel_update
  );
endinterface

// File: rtl/fmesh_presel_ctrl.sv
// Congestion-driven port pre-selection for fmesh adaptive routing.
// Integrates per-direction occupancy (MAX_CREDIT - free credits) over a
// WINDOW-cycle window, then compares X vs Y candidates per quadrant with
// hysteresis to reload port_pre_sel.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : slave side of fmesh_presel_ctrl_if (enable, credit_avb in;
//           port_pre_sel, presel_update out, both registered)
module fmesh_presel_ctrl #(
  parameter int unsigned WINDOW         = 64,
  parameter int unsigned CRDw           = 4,
  parameter int unsigned MAX_CREDIT     = 4,
  parameter int unsigned ACCw           = 12,
  parameter int unsigned HYST           = 4,
  parameter logic [3:0]  DEFAULT_PRESEL = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  fmesh_presel_ctrl_if.slave bus
);

  localparam int unsigned     CNTw     = $clog2(WINDOW);
  localparam logic [CNTw-1:0] CNT_LAST = CNTw'(WINDOW - 1);
  localparam logic [ACCw:0]   HYST_W   = (ACCw+1)'(HYST);
  localparam logic [CRDw-1:0] MAXC     = CRDw'(MAX_CREDIT);

  typedef enum logic [1:0] {
    ST_DIS = 2'd0,
    ST_ACC = 2'd1,
    ST_CMP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [ACCw-1:0] acc_q [4];
  logic [ACCw-1:0] acc_d [4];
  logic [CNTw-1:0] cnt_q, cnt_d;
  logic [3:0]      sel_q, sel_d;
  logic            upd_q, upd_d;
  logic [CRDw-1:0] occ [4];

  // Occupancy per direction; credit counts above MAX_CREDIT read as empty.
  always_comb begin
    logic [CRDw-1:0] crd;
    crd = '0;
    for (int d = 0; d < 4; d++) begin
      occ[d] = '0;
      crd    = bus.credit_avb[d*CRDw +: CRDw];
      if (crd <= MAXC) occ[d] = MAXC - crd;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_DIS;
    else       state_q <= state_d;
  end

  // Next-state logic; dropping enable always returns to DIS.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = ST_DIS;
    end else begin
      unique case (state_q)
        ST_DIS:  state_d = ST_ACC;
        ST_ACC:  if (cnt_q == CNT_LAST) state_d = ST_CMP;
        ST_CMP:  state_d = ST_ACC;
        default: state_d = ST_DIS;
      endcase
    end
  end

  // Datapath/output logic: accumulate, compare, reload.
  always_comb begin
    logic [ACCw:0] sum;
    logic [ACCw:0] a;
    logic [ACCw:0] b;
    logic [1:0]    qv;
    logic [1:0]    xd;
    logic [1:0]    yd;
    for (int d = 0; d < 4; d++) acc_d[d] = acc_q[d];
    cnt_d = cnt_q;
    sel_d = sel_q;
    upd_d = 1'b0;
    sum   = '0;
    a     = '0;
    b     = '0;
    qv    = '0;
    xd    = '0;
    yd    = '0;
    if (!bus.enable) begin
      for (int d = 0; d < 4; d++) acc_d[d] = '0;
      cnt_d = '0;
      sel_d = DEFAULT_PRESEL;
    end else begin
      unique case (state_q)
        ST_DIS: begin
          for (int d = 0; d < 4; d++) acc_d[d] = '0;
          cnt_d = '0;
          sel_d = DEFAULT_PRESEL;
        end
        ST_ACC: begin
          // Carry out of the ACCw-bit add means saturation.
          for (int d = 0; d < 4; d++) begin
            sum      = {1'b0, acc_q[d]} + (ACCw+1)'(occ[d]);
            acc_d[d] = sum[ACCw] ? '1 : sum[ACCw-1:0];
          end
          cnt_d = cnt_q + CNTw'(1);
        end
        ST_CMP: begin
          // Quadrant q={x,y}: X cand E(x=1)/W(x=0), Y cand N(y=1)/S(y=0).
          for (int q = 0; q < 4; q++) begin
            qv = 2'(q);
            xd = qv[1] ? 2'd0 : 2'd2;
            yd = qv[0] ? 2'd1 : 2'd3;
            a  = {1'b0, acc_q[xd]};
            b  = {1'b0, acc_q[yd]};
            if (a > b + HYST_W)      sel_d[q] = 1'b1;
            else if (b > a + HYST_W) sel_d[q] = 1'b0;
          end
          for (int d = 0; d < 4; d++) acc_d[d] = '0;
          cnt_d = '0;
          upd_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 4; d++) acc_q[d] <= '0;
      cnt_q <= '0;
      sel_q <= DEFAULT_PRESEL;
      upd_q <= 1'b0;
    end else begin
      for (int d = 0; d < 4; d++) acc_q[d] <= acc_d[d];
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      upd_q <= upd_d;
    end
  end

  assign bus.port_pre_sel  = sel_q;
  assign bus.presel_update = upd_q;

endmodule

// File: tb/tb_fmesh_presel_ctrl.sv
// Bench for fmesh_presel_ctrl: a WINDOW=8/ACCw=12 instance and a
// WINDOW=32/ACCw=6 instance share stimulus and are compared every cycle
// against a window-level reference model.
module tb_fmesh_presel_ctrl;

  localparam int unsigned W0   = 8;
  localparam int unsigned W1   = 32;
  localparam int unsigned CRDW = 4;
  localparam int          MAXC = 4;
  localparam int          HYST = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              enable;
  logic [4*CRDW-1:0] credit;

  fmesh_presel_ctrl_if #(.CRDw(CRDW)) if0 ();
  fmesh_presel_ctrl_if #(.CRDw(CRDW)) if1 ();

  assign if0.enable     = enable;
  assign if0.credit_avb = credit;
  assign if1.enable     = enable;
  assign if1.credit_avb = credit;

  fmesh_presel_ctrl #(
    .WINDOW(W0), .CRDw(CRDW), .MAX_CREDIT(4), .ACCw(12), .HYST(4),
    .DEFAULT_PRESEL(4'b0000)
  ) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );

  fmesh_presel_ctrl #(
    .WINDOW(W1), .CRDw(CRDW), .MAX_CREDIT(4), .ACCw(6), .HYST(4),
    .DEFAULT_PRESEL(4'b0000)
  ) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  // Reference model state, one slot per instance.
  int         win_m   [2];
  int         amax_m  [2];
  bit         idle_m  [2];
  int         taken_m [2];
  int         sum_m   [2][4];
  logic [3:0] sel_m   [2];
  logic       upd_m   [2];

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int occ_of(input int d);
    logic [3:0] c;
    c = credit[d*4 +: 4];
    return (int'(c) > MAXC) ? 0 : MAXC - int'(c);
  endfunction

  // One clock edge of the window-level behaviour.
  task automatic model_edge(input int i);
    int xa, yb, s;
    if (reset || !enable) begin
      idle_m[i]  = 1'b1;
      taken_m[i] = 0;
      for (int d = 0; d < 4; d++) sum_m[i][d] = 0;
      sel_m[i]   = 4'b0000;
      upd_m[i]   = 1'b0;
    end else if (idle_m[i]) begin
      idle_m[i] = 1'b0;
      upd_m[i]  = 1'b0;
    end else if (taken_m[i] < win_m[i]) begin
      for (int d = 0; d < 4; d++) begin
        s = sum_m[i][d] + occ_of(d);
        sum_m[i][d] = (s > amax_m[i]) ? amax_m[i] : s;
      end
      taken_m[i]++;
      upd_m[i] = 1'b0;
    end else begin
      for (int q = 0; q < 4; q++) begin
        xa = (q >= 2) ? sum_m[i][0] : sum_m[i][2];
        yb = (q % 2 == 1) ? sum_m[i][1] : sum_m[i][3];
        if (xa > yb + HYST)      sel_m[i][q] = 1'b1;
        else if (yb > xa + HYST) sel_m[i][q] = 1'b0;
      end
      for (int d = 0; d < 4; d++) sum_m[i][d] = 0;
      taken_m[i] = 0;
      upd_m[i]   = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("sel_w8",  32'(if0.port_pre_sel),  32'(sel_m[0]));
    chk("upd_w8",  32'(if0.presel_update), 32'(upd_m[0]));
    chk("sel_w32", 32'(if1.port_pre_sel),  32'(sel_m[1]));
    chk("upd_w32", 32'(if1.presel_update), 32'(upd_m[1]));
  endtask

  task automatic set_cr(input int e, input int n, input int w, input int s);
    credit = {4'(s), 4'(w), 4'(n), 4'(e)};
  endtask

  task automatic run_until_pulse(input int i, input int bound, output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    while (!done && n < bound) begin
      step();
      n++;
      if (((i == 0) ? if0.presel_update : if1.presel_update) === 1'b1) done = 1'b1;
    end
    if (!done) chk("pulse_timeout", 32'(n), 32'(bound + 1));
  endtask

  initial begin
    int n;
    int lv [4];
    checks    = 0;
    errors    = 0;
    win_m[0]  = W0;
    win_m[1]  = W1;
    amax_m[0] = 4095;
    amax_m[1] = 63;
    for (int i = 0; i < 2; i++) begin
      idle_m[i]  = 1'b1;
      taken_m[i] = 0;
      sel_m[i]   = 4'b0000;
      upd_m[i]   = 1'b0;
      for (int d = 0; d < 4; d++) sum_m[i][d] = 0;
    end

    // Reset held two cycles with enable high and arbitrary credits.
    reset  = 1'b1;
    enable = 1'b1;
    credit = 16'($urandom);
    step();
    step();
    chk("rst_sel", 32'(if0.port_pre_sel), 32'h0);
    chk("rst_upd", 32'(if0.presel_update), 32'h0);

    // East congested: first pulse timing after release, then a second window.
    reset = 1'b0;
    set_cr(0, 4, 4, 4);
    run_until_pulse(0, 40, n);
    chk("first_pulse_lat", 32'(n), 32'(W0 + 2));
    chk("east_sel", 32'(if0.port_pre_sel), 32'hC);
    run_until_pulse(0, 40, n);
    chk("period", 32'(n), 32'(W0 + 1));
    chk("east_sel2", 32'(if0.port_pre_sel), 32'hC);

    // Hysteresis: N lightly loaded flips bit3; then a within-margin window holds.
    set_cr(4, 3, 4, 4);
    run_until_pulse(0, 40, n);
    chk("hyst_period", 32'(n), 32'(W0 + 1));
    chk("hyst_sel", 32'(if0.port_pre_sel), 32'h4);
    for (int k = 0; k <= int'(W0); k++) begin
      set_cr((k < 4) ? 3 : 4, 4, 4, 4);
      step();
    end
    chk("hold_upd", 32'(if0.presel_update), 32'h1);
    chk("hold_sel", 32'(if0.port_pre_sel), 32'h4);

    // Saturation on the narrow-accumulator instance.
    enable = 1'b0;
    step();
    chk("dis_sel", 32'(if0.port_pre_sel), 32'h0);
    enable = 1'b1;
    set_cr(4, 4, 0, 4);
    run_until_pulse(1, 100, n);
    chk("sat_lat", 32'(n), 32'(W1 + 2));
    chk("sat_sel", 32'(if1.port_pre_sel), 32'h3);

    // Enable drop mid-window (cnt=5) from 4'b1100.
    enable = 1'b0;
    step();
    enable = 1'b1;
    set_cr(0, 4, 4, 4);
    run_until_pulse(0, 40, n);
    chk("en_lat", 32'(n), 32'(W0 + 2));
    chk("en_sel", 32'(if0.port_pre_sel), 32'hC);
    repeat (5) step();
    enable = 1'b0;
    step();
    chk("drop_sel", 32'(if0.port_pre_sel), 32'h0);
    chk("drop_upd", 32'(if0.presel_update), 32'h0);
    enable = 1'b1;
    run_until_pulse(0, 40, n);
    chk("reen_lat", 32'(n), 32'(W0 + 2));
    chk("reen_sel", 32'(if0.port_pre_sel), 32'hC);

    // Reset landing on the CMP cycle drops the result.
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (W0 + 1) step();
    reset = 1'b1;
    step();
    chk("rcmp_sel", 32'(if0.port_pre_sel), 32'h0);
    chk("rcmp_upd", 32'(if0.presel_update), 32'h0);
    reset = 1'b0;
    repeat (3) step();

    // Randomized traffic with per-direction load levels.
    for (int d = 0; d < 4; d++) lv[d] = 0;
    for (int t = 0; t < 3000; t++) begin
      if (t % 16 == 0)
        for (int d = 0; d < 4; d++) lv[d] = int'($urandom_range(0, 7));
      for (int d = 0; d < 4; d++)
        credit[d*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 7)) : 4'(lv[d]);
      enable = ($urandom_range(0, 99) >= 2);
      reset  = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmesh_presel_ctrl.md
# fmesh_presel_ctrl

Congestion-driven port pre-selection controller for adaptive routing in the fmesh router. It samples free-credit counts of the four mesh output directions (E, N, W, S) over a fixed window and integrates occupancy per direction. At each window boundary it recomputes the 4-bit `port_pre_sel` vector consumed by the fmesh destination-port decoder's adaptive path. One instance sits per router, beside the output-port credit counters.

## Interface
- `WINDOW`, 64: sampling window length in cycles, ≥2.
- `CRDw`, 4: width of each credit count.
- `MAX_CREDIT`, 4: credits at an empty downstream buffer.
- `ACCw`, 12: per-direction accumulator width.
- `HYST`, 4: hysteresis margin in accumulator units.
- `DEFAULT_PRESEL`, 4'b0000: `port_pre_sel` value after reset and while disabled.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: controller active.
- `credit_avb` in 4*CRDw: free credits, packed as slice d = direction d, with 0=E, 1=N, 2=W, 3=S.
- `port_pre_sel` out 4: bit q = {x,y} selects the Y port (1) or the X port (0) for quadrant q.
- `presel_update` out 1: one-cycle pulse when `port_pre_sel` is reloaded from a window result.

## Operation
- Quadrant mapping, for q = {x,y}:
  - X candidate is E if x=1, W if x=0.
  - Y candidate is N if y=1, S if y=0.
- Occupancy per direction: occ[d] = MAX_CREDIT − credit_avb[d]. If credit_avb[d] > MAX_CREDIT, occ[d] = 0.
- FSM states:
  - DIS: accumulators and counter held at 0. `port_pre_sel`=DEFAULT_PRESEL. Moves to ACC when `enable`=1.
  - ACC: each cycle, acc[d] ← sat(acc[d]+occ[d]), saturating at 2^ACCw−1, and cnt increments. When cnt==WINDOW−1, that cycle's sample is included and the FSM moves to CMP.
  - CMP: for each q, with A=acc[Xcand] and B=acc[Ycand] computed at ACCw+1 bits (no overflow):
    - If A > B+HYST, sel[q] ← 1.
    - Else if B > A+HYST, sel[q] ← 0.
    - Otherwise sel[q] holds its value.
    - Accumulators clear, cnt clears, and the FSM returns to ACC. The CMP-cycle sample is discarded.
- `presel_update` is registered high for the one cycle after CMP, even if no bit changed.
- In any state, `enable`=0 takes effect in the next cycle:
  - state DIS, accumulators cleared, `port_pre_sel`=DEFAULT_PRESEL, no update pulse.
  - A partial window is discarded.
- `reset` overrides everything, including a CMP in progress. Its result is dropped.

## Timing
- Reset values (cycle after `reset` sampled high): state DIS, acc=0, cnt=0, `port_pre_sel`=DEFAULT_PRESEL, `presel_update`=0.
- `enable` sampled high at edge k puts the FSM in ACC for cycles k+1 … k+WINDOW, and CMP in cycle k+WINDOW+1.
- The new `port_pre_sel` and the `presel_update` pulse are both visible in cycle k+WINDOW+2.
- Steady-state period is WINDOW+1 cycles per update.
- `port_pre_sel` is registered and changes only in the cycle after CMP, after a DIS entry, or after reset. It is glitch-free toward the decoder.
- `credit_avb` is sampled at the rising edge. No input is combinationally used by any output.

## Test plan
Bench parameters: WINDOW=8, MAX_CREDIT=4, HYST=4, ACCw=12 unless a scenario says otherwise.

1. **Reset.** Assert `reset` for 2 cycles, `enable`=1, with arbitrary credits. Required: `port_pre_sel`=4'b0000 and `presel_update`=0 throughout, and first pulse exactly WINDOW+2 cycles after `reset` is released.
2. **East congested.** credit E=0; N, W, S=4. Required: accE=32, others 0, giving `port_pre_sel`=4'b1100 with a one-cycle `presel_update` pulse. A second identical window gives 4'b1100 again with a pulse.
3. **Hysteresis hold.** Start from state 4'b1100. Next window: credit E=4, N=3 (accN=8, accE=0), and S=4, W=4. Required: bit3 → 0 (8 > 0+4), bit2 holds 1 (S=0, E=0), giving 4'b0100. Then a window with N=4 and E such that accE=4, accN=0. Required: bit3 holds (4 not > 0+4).
4. **Saturation.** ACCw=6, WINDOW=32, credit W=0, S=4. Required: accW saturates at 63, no wrap, and bit0 → 1.
5. **Enable drop.** Deassert `enable` at cnt=5 with `port_pre_sel`=4'b1100. Required: the next cycle shows 4'b0000 with no pulse. On re-enable, a full 8-cycle window runs before the next pulse.
6. **Reset during CMP.** Assert `reset` in the CMP cycle of scenario 2. Required: `port_pre_sel` stays 4'b0000 and no `presel_update` pulse appears.
